// File: rtl/soft_error_monitor_pkg.sv
// Shared definitions for the soft-error monitor.
// Contents:
//   CNT_W          width of every error counter and threshold
//   N_CHAN         number of monitored error classes
//   CH_*           channel index of each error class
//   CNT_MAX        saturation value of a counter
//   chan_state_e   per-channel flag state machine encoding
package soft_error_monitor_pkg;

  localparam int CNT_W  = 32;
  localparam int N_CHAN = 3;

  localparam int CH_DATA_CORRUPT  = 0;
  localparam int CH_UNKNOWN_TTC   = 1;
  localparam int CH_DDR3_OVERFLOW = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_TRIPPED  = 2'd1,
    ST_DISABLED = 2'd2
  } chan_state_e;

endpackage

// File: rtl/soft_error_chan.sv
// One soft-error channel: a saturating event counter plus a sticky flag
// raised once the count reaches a programmable threshold.
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   event_in   one pulse per error event (held high counts once per cycle)
//   clear      clears count and flag, returns the state machine to ARMED
//   threshold  live trip threshold; zero disables the flag
//   count      saturating event count
//   flag       sticky flag, high while the channel is TRIPPED
module soft_error_chan
  import soft_error_monitor_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             event_in,
  input  logic             clear,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] count,
  output logic             flag
);

  logic [CNT_W-1:0] count_d, count_q;
  chan_state_e      state_d, state_q;

  // Next count: a clear restarts from zero but still keeps an event that
  // arrives in the same cycle, so nothing is lost across a clear. Outside
  // a clear the counter increments and sticks at its maximum value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {{(CNT_W-1){1'b0}}, event_in};
    end else if (event_in && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Flag state machine. The compare looks at the registered count against
  // the live threshold, so the flag lags the count by one cycle. Once
  // TRIPPED only a clear (or reset) gets the channel out again, whatever
  // happens to the threshold afterwards. Leaving DISABLED goes through
  // ARMED so the compare happens on the following cycle.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (threshold == '0) begin
            state_d = ST_DISABLED;
          end else if (count_q >= threshold) begin
            state_d = ST_TRIPPED;
          end
        end
        ST_TRIPPED: begin
          state_d = ST_TRIPPED;
        end
        ST_DISABLED: begin
          if (threshold != '0) begin
            state_d = ST_ARMED;
          end
        end
        default: begin
          state_d = ST_ARMED;
        end
      endcase
    end
  end

  // State registers; reset drops the count and flag immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      state_q <= ST_ARMED;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign count = count_q;
  assign flag  = (state_q == ST_TRIPPED);

endmodule

// File: rtl/soft_error_monitor.sv
// Soft-error monitor feeding the status register block. Counts checksum
// mismatches, unknown TTC broadcast commands and DDR3 overflows, and raises
// a sticky flag per class when its count reaches the programmed threshold.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   cs_mismatch                  checksum mismatch event pulse
//   unknown_cmd                  unknown TTC broadcast command pulse
//   ddr3_overflow                DDR3 overflow event pulse
//   thres_*                      per-class thresholds, zero disables the flag
//   soft_err_clear               clears all counts and flags
//   *_count                      saturating per-class counts
//   error_data_corrupt           sticky hard error, checksum mismatches
//   error_unknown_ttc            sticky hard error, unknown TTC commands
//   ddr3_overflow_warning        sticky warning, DDR3 overflows
module soft_error_monitor
  import soft_error_monitor_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             cs_mismatch,
  input  logic             unknown_cmd,
  input  logic             ddr3_overflow,
  input  logic [CNT_W-1:0] thres_data_corrupt,
  input  logic [CNT_W-1:0] thres_unknown_ttc,
  input  logic [CNT_W-1:0] thres_ddr3_overflow,
  input  logic             soft_err_clear,
  output logic [CNT_W-1:0] cs_mismatch_count,
  output logic [CNT_W-1:0] unknown_cmd_count,
  output logic [CNT_W-1:0] ddr3_overflow_count,
  output logic             error_data_corrupt,
  output logic             error_unknown_ttc,
  output logic             ddr3_overflow_warning
);

  logic [N_CHAN-1:0] event_vec;
  logic [N_CHAN-1:0] flag_vec;
  logic [CNT_W-1:0]  thres_vec [N_CHAN];
  logic [CNT_W-1:0]  count_vec [N_CHAN];

  assign event_vec[CH_DATA_CORRUPT]  = cs_mismatch;
  assign event_vec[CH_UNKNOWN_TTC]   = unknown_cmd;
  assign event_vec[CH_DDR3_OVERFLOW] = ddr3_overflow;

  assign thres_vec[CH_DATA_CORRUPT]  = thres_data_corrupt;
  assign thres_vec[CH_UNKNOWN_TTC]   = thres_unknown_ttc;
  assign thres_vec[CH_DDR3_OVERFLOW] = thres_ddr3_overflow;

  // The channels are fully independent; only the clear is shared.
  for (genvar ch = 0; ch < N_CHAN; ch++) begin : g_chan
    soft_error_chan u_chan (
      .clk       (clk),
      .reset     (reset),
      .event_in  (event_vec[ch]),
      .clear     (soft_err_clear),
      .threshold (thres_vec[ch]),
      .count     (count_vec[ch]),
      .flag      (flag_vec[ch])
    );
  end

  assign cs_mismatch_count     = count_vec[CH_DATA_CORRUPT];
  assign unknown_cmd_count     = count_vec[CH_UNKNOWN_TTC];
  assign ddr3_overflow_count   = count_vec[CH_DDR3_OVERFLOW];
  assign error_data_corrupt    = flag_vec[CH_DATA_CORRUPT];
  assign error_unknown_ttc     = flag_vec[CH_UNKNOWN_TTC];
  assign ddr3_overflow_warning = flag_vec[CH_DDR3_OVERFLOW];

endmodule

// File: tb/tb_soft_error_monitor.sv
// Testbench for soft_error_monitor: directed stimulus with hand-computed
// expectations queued against the clock cycle on which they must appear.
module tb_soft_error_monitor;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        cs_mismatch;
  logic        unknown_cmd;
  logic        ddr3_overflow;
  logic [31:0] thres_data_corrupt;
  logic [31:0] thres_unknown_ttc;
  logic [31:0] thres_ddr3_overflow;
  logic        soft_err_clear;
  logic [31:0] cs_mismatch_count;
  logic [31:0] unknown_cmd_count;
  logic [31:0] ddr3_overflow_count;
  logic        error_data_corrupt;
  logic        error_unknown_ttc;
  logic        ddr3_overflow_warning;

  exp_t sb[$];
  int   cyc;
  int   total;
  int   bad;

  soft_error_monitor dut (
    .clk                   (clk),
    .reset                 (reset),
    .cs_mismatch           (cs_mismatch),
    .unknown_cmd           (unknown_cmd),
    .ddr3_overflow         (ddr3_overflow),
    .thres_data_corrupt    (thres_data_corrupt),
    .thres_unknown_ttc     (thres_unknown_ttc),
    .thres_ddr3_overflow   (thres_ddr3_overflow),
    .soft_err_clear        (soft_err_clear),
    .cs_mismatch_count     (cs_mismatch_count),
    .unknown_cmd_count     (unknown_cmd_count),
    .ddr3_overflow_count   (ddr3_overflow_count),
    .error_data_corrupt    (error_data_corrupt),
    .error_unknown_ttc     (error_unknown_ttc),
    .ddr3_overflow_warning (ddr3_overflow_warning)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index: number of rising edges seen so far.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Select one observable output: 0..2 counts, 3..5 flags.
  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return cs_mismatch_count;
      1:       return unknown_cmd_count;
      2:       return ddr3_overflow_count;
      3:       return {31'd0, error_data_corrupt};
      4:       return {31'd0, error_unknown_ttc};
      default: return {31'd0, ddr3_overflow_warning};
    endcase
  endfunction

  // Queue an expectation to be checked at the falling edge `delay` cycles on.
  task automatic checkOutput(input int delay, input string name, input int sel,
                             input logic [31:0] val);
    exp_t e;
    e.cyc  = cyc + delay;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Drive one cycle of event/clear inputs, then advance to the next falling edge.
  task automatic applyStimulus(input logic e0, input logic e1, input logic e2,
                               input logic clr);
    cs_mismatch    = e0;
    unknown_cmd    = e1;
    ddr3_overflow  = e2;
    soft_err_clear = clr;
    @(negedge clk);
  endtask

  // Monitor: at each falling edge, compare every expectation due now and
  // report any that were due earlier and never checked.
  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        act   = observe(sb[i].sel);
        total = total + 1;
        if (act !== sb[i].val) begin
          bad = bad + 1;
          $display("[TB] FAIL %s: got %h expected %h (cycle %0d)",
                   sb[i].name, act, sb[i].val, cyc);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        total = total + 1;
        bad   = bad + 1;
        $display("[TB] FAIL %s: got no check expected check at cycle %0d", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end else begin
        i = i + 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total               = 0;
    bad                 = 0;
    reset               = 1'b1;
    cs_mismatch         = 1'b0;
    unknown_cmd         = 1'b0;
    ddr3_overflow       = 1'b0;
    soft_err_clear      = 1'b0;
    thres_data_corrupt  = 32'd0;
    thres_unknown_ttc   = 32'd0;
    thres_ddr3_overflow = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset state");
    for (int s = 0; s < 6; s++) checkOutput(1, "reset_state", s, 32'd0);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] data corrupt, threshold 3");
    thres_data_corrupt = 32'd3;
    checkOutput(1, "t1_count_1", 0, 32'd1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput(1, "t1_count_2", 0, 32'd2);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput(1, "t1_count_3", 0, 32'd3);
    checkOutput(1, "t1_flag_early", 3, 32'd0);
    checkOutput(2, "t1_flag", 3, 32'd1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] unknown ttc disabled, 100 events");
    for (int i = 0; i < 100; i++) begin
      if (i == 99) begin
        checkOutput(1, "t2_count_100", 1, 32'd100);
        checkOutput(1, "t2_flag_off_a", 4, 32'd0);
        checkOutput(2, "t2_flag_off_b", 4, 32'd0);
      end
      applyStimulus(0, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0);
    thres_unknown_ttc = 32'd50;
    checkOutput(1, "t2_flag_rearm", 4, 32'd0);
    checkOutput(2, "t2_flag_trip", 4, 32'd1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] ddr3 warning sticky across threshold change, then clear");
    thres_ddr3_overflow = 32'd2;
    applyStimulus(0, 0, 1, 0);
    checkOutput(1, "t3_count_2", 2, 32'd2);
    checkOutput(1, "t3_warn_early", 5, 32'd0);
    checkOutput(2, "t3_warn", 5, 32'd1);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    thres_ddr3_overflow = 32'd1000;
    checkOutput(1, "t3_warn_hold_a", 5, 32'd1);
    checkOutput(3, "t3_warn_hold_b", 5, 32'd1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput(1, "t3_clr_count2", 2, 32'd0);
    checkOutput(1, "t3_clr_warn", 5, 32'd0);
    checkOutput(1, "t3_clr_count0", 0, 32'd0);
    checkOutput(1, "t3_clr_flag0", 3, 32'd0);
    checkOutput(1, "t3_clr_count1", 1, 32'd0);
    checkOutput(1, "t3_clr_flag1", 4, 32'd0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] clear coinciding with event, threshold 1");
    thres_data_corrupt = 32'd1;
    checkOutput(1, "t4_count_1", 0, 32'd1);
    checkOutput(1, "t4_flag_early", 3, 32'd0);
    checkOutput(2, "t4_flag", 3, 32'd1);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] threshold lowered below count while armed");
    applyStimulus(0, 0, 0, 1);
    thres_unknown_ttc = 32'd10;
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput(1, "t5_count_3", 1, 32'd3);
    checkOutput(1, "t5_flag_armed", 4, 32'd0);
    applyStimulus(0, 0, 0, 0);
    thres_unknown_ttc = 32'd2;
    checkOutput(1, "t5_flag_lowered", 4, 32'd1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] saturation at all-ones");
    applyStimulus(0, 0, 0, 1);
    thres_data_corrupt = 32'hFFFF_FFFF;
    force dut.g_chan[0].u_chan.count_d = 32'hFFFF_FFFE;
    checkOutput(1, "t6_preload", 0, 32'hFFFF_FFFE);
    applyStimulus(0, 0, 0, 0);
    release dut.g_chan[0].u_chan.count_d;
    checkOutput(1, "t6_sat", 0, 32'hFFFF_FFFF);
    checkOutput(1, "t6_flag_early", 3, 32'd0);
    checkOutput(2, "t6_flag", 3, 32'd1);
    applyStimulus(1, 0, 0, 0);
    checkOutput(1, "t6_hold_a", 0, 32'hFFFF_FFFF);
    applyStimulus(1, 0, 0, 0);
    checkOutput(1, "t6_hold_b", 0, 32'hFFFF_FFFF);
    applyStimulus(1, 0, 0, 0);
    checkOutput(1, "t6_hold_c", 0, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] all channels at once, then async reset");
    applyStimulus(0, 0, 0, 1);
    thres_data_corrupt  = 32'd1;
    thres_unknown_ttc   = 32'd1;
    thres_ddr3_overflow = 32'd1;
    checkOutput(1, "t7_count0", 0, 32'd1);
    checkOutput(1, "t7_count1", 1, 32'd1);
    checkOutput(1, "t7_count2", 2, 32'd1);
    checkOutput(2, "t7_flag0", 3, 32'd1);
    checkOutput(2, "t7_flag1", 4, 32'd1);
    checkOutput(2, "t7_flag2", 5, 32'd1);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int s = 0; s < 6; s++) checkOutput(0, "t7_async_reset", s, 32'd0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    #1;

    if (sb.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("[TB] FAIL leftover_checks: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
